req_encoder: RTL and testbench

Registered N-to-log2(N) priority encoder with request capture: the inverse of the team's 2-4 decoder, sitting on the request side. Single-cycle request pulses on one-hot/multi-hot lines are latched into a pending register. They are served highest-index-first as binary codes over a valid/ready handshake, so the downstream decoder/consumer can stall without losing requests. Requests that arrive for an already-pending line are counted as dropped via a sticky flag.

---
 rtl/req_encoder.sv | 111 +++++++++++
 tb/tb_req_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder.sv
// req_encoder
//   Registered priority encoder with request capture. Request pulses are
//   latched into a pending register and served highest-index-first as binary
//   codes over a valid/ready handshake. A request that lands on a line that is
//   still pending is lost and raises a sticky drop flag.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         capture enable (0: new requests ignored, pending still served)
//   req[N]     request lines, any number may be high
//   out_valid  out_code holds a served request
//   out_ready  consumer accepts out_code this cycle
//   out_code   index of the served request line
//   pending[N] current pending register
//   drop       sticky: a request hit an already-pending line
//   drop_clr   synchronous clear of drop
module req_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         drop,
  input  logic         drop_clr
);

  // The output stage is the only state beyond the pending register:
  // IDLE means nothing presented, HOLD means out_code is being offered.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stage_e;

  stage_e       stage_q, stage_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         drop_q, drop_d;

  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [W-1:0] top_idx;
  logic         load;

  // Index of the highest set bit; later (higher) iterations overwrite earlier.
  function automatic logic [W-1:0] hi_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    set       = req & {N{en}};
    top_idx   = hi_index(pending_q);
    // Selection works only from the registered pending bits, never from req,
    // so a fresh request always takes one edge to become servable.
    load      = (|pending_q) && ((stage_q == IDLE) || out_ready);
    clr       = '0;
    stage_d   = stage_q;
    code_d    = code_q;

    if (load) begin
      clr[top_idx] = 1'b1;
      stage_d      = HOLD;
      code_d       = top_idx;
    end else if ((stage_q == HOLD) && out_ready) begin
      stage_d = IDLE;
    end

    // Set is ORed after the clear so a re-request in the serving cycle survives.
    pending_d = (pending_q & ~clr) | set;

    // A new collision takes precedence over a clear request in the same cycle.
    if (|(set & pending_q & ~clr)) begin
      drop_d = 1'b1;
    end else if (drop_clr) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      drop_q    <= drop_d;
    end
  end

  assign out_valid = (stage_q == HOLD);
  assign out_code  = code_q;
  assign pending   = pending_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_req_encoder.sv
module tb_req_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic [N-1:0] pending;
  logic         drop;
  logic         drop_clr;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];

  req_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .pending  (pending),
    .drop     (drop),
    .drop_clr (drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks happen at the falling edge, away from the active edge.
  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: every accepted code must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", exp_q.size(), 1);
      end else begin
        chk("sb_code", {30'b0, out_code}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset held with requests active
    rst_n = 1'b0; en = 1'b1; req = 4'b1111; out_ready = 1'b1; drop_clr = 1'b0;
    tick(); tick(); tick();
    mid();
    chk("rst_pending", {28'b0, pending}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_code", {30'b0, out_code}, 0);
    chk("rst_drop", {31'b0, drop}, 0);
    tick();
    req = 4'b0000; rst_n = 1'b1;
    tick(); tick();
    mid();
    chk("rel_valid", {31'b0, out_valid}, 0);
    chk("rel_pending", {28'b0, pending}, 0);

    // Single request: visible in pending after E0, served after E1
    tick();
    req = 4'b0100; exp_q.push_back(2);
    tick();
    req = 4'b0000;
    mid();
    chk("single_pend", {28'b0, pending}, 4'b0100);
    chk("single_lat_valid0", {31'b0, out_valid}, 0);
    tick();
    mid();
    chk("single_valid", {31'b0, out_valid}, 1);
    chk("single_code", {30'b0, out_code}, 2);
    chk("single_pend_clr", {28'b0, pending}, 0);
    tick();
    mid();
    chk("single_one_cycle", {31'b0, out_valid}, 0);
    chk("single_drop", {31'b0, drop}, 0);

    // Multi-hot drain: 3,1,0 back to back
    tick();
    req = 4'b1011; exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
    tick();
    req = 4'b0000;
    tick();
    mid(); chk("multi_c3", {30'b0, out_code}, 3);
    tick();
    mid(); chk("multi_c1", {30'b0, out_code}, 1); chk("multi_v1", {31'b0, out_valid}, 1);
    tick();
    mid(); chk("multi_c0", {30'b0, out_code}, 0); chk("multi_v0", {31'b0, out_valid}, 1);
    tick();
    mid(); chk("multi_done", {31'b0, out_valid}, 0);

    // Backpressure: code 0 held while 1000 accumulates
    tick();
    out_ready = 1'b0; req = 4'b0001; exp_q.push_back(0);
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1000; exp_q.push_back(3);
    tick();
    req = 4'b0000;
    mid();
    chk("bp_valid", {31'b0, out_valid}, 1);
    chk("bp_code", {30'b0, out_code}, 0);
    chk("bp_pend", {28'b0, pending}, 4'b1000);
    tick();
    mid();
    chk("bp_hold_code", {30'b0, out_code}, 0);
    chk("bp_hold_pend", {28'b0, pending}, 4'b1000);
    tick();
    out_ready = 1'b1;
    tick();
    mid();
    chk("bp_next_code", {30'b0, out_code}, 3);
    tick();
    out_ready = 1'b0;
    mid();
    chk("bp_drained", {31'b0, out_valid}, 0);

    // Drop: stall on code 0, then hit bit 1 twice
    tick();
    req = 4'b0001; exp_q.push_back(0);
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010; exp_q.push_back(1);
    tick();
    mid(); chk("drop_not_yet", {31'b0, drop}, 0);
    tick();
    req = 4'b0000;
    mid(); chk("drop_set", {31'b0, drop}, 1);
    // Collision and clear in the same cycle: collision wins
    req = 4'b0010; drop_clr = 1'b1;
    tick();
    req = 4'b0000;
    mid(); chk("drop_wins_clr", {31'b0, drop}, 1);
    tick();
    drop_clr = 1'b0;
    mid(); chk("drop_cleared", {31'b0, drop}, 0);
    out_ready = 1'b1;
    tick();
    mid(); chk("drop_drain_code", {30'b0, out_code}, 1);
    tick();
    mid(); chk("drop_drained", {31'b0, out_valid}, 0);

    // Set wins over clear: re-request bit 2 on the edge it is loaded
    tick();
    req = 4'b0100; exp_q.push_back(2);
    tick();
    req = 4'b0100; exp_q.push_back(2);
    tick();
    req = 4'b0000;
    mid();
    chk("sw_code", {30'b0, out_code}, 2);
    chk("sw_pend", {28'b0, pending}, 4'b0100);
    chk("sw_drop", {31'b0, drop}, 0);
    tick();
    mid();
    chk("sw_again_valid", {31'b0, out_valid}, 1);
    chk("sw_again_pend", {28'b0, pending}, 0);
    tick();
    mid(); chk("sw_done", {31'b0, out_valid}, 0);

    // Enable low: requests ignored
    tick();
    en = 1'b0; req = 4'b1111;
    tick(); tick();
    mid();
    chk("en_pend", {28'b0, pending}, 0);
    chk("en_valid", {31'b0, out_valid}, 0);
    chk("en_drop", {31'b0, drop}, 0);

    // Reset mid-stall discards pending and held output at once
    tick();
    en = 1'b1; req = 4'b0110; out_ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    mid();
    chk("rs_valid", {31'b0, out_valid}, 1);
    chk("rs_code", {30'b0, out_code}, 2);
    chk("rs_pend", {28'b0, pending}, 4'b0010);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_async_pend", {28'b0, pending}, 0);
    chk("rs_async_valid", {31'b0, out_valid}, 0);
    chk("rs_async_code", {30'b0, out_code}, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick(); tick();
    mid();
    chk("rs_after_valid", {31'b0, out_valid}, 0);
    chk("rs_after_pend", {28'b0, pending}, 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
